// File: rtl/gpu_dispatch_pkg.sv
// +-----------------------------------------------------------------------------+
// | gpu_dispatch_pkg : shared state encodings and helpers for the dispatcher    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

package gpu_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } slot_state_t;

    // Width of a per-block thread count for the default block size.
    localparam int TPB_DEFAULT = 4;
    localparam int TC_BITS     = $clog2(TPB_DEFAULT) + 1;

    // ceil(count / 2**lg) using only a shift and a mask test.
    function automatic logic [31:0] ceil_div_pow2(input logic [31:0] count, input int lg);
        logic [31:0] mask;
        mask = (32'd1 << lg) - 32'd1;
        return (count >> lg) + (((count & mask) != 32'd0) ? 32'd1 : 32'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dispatch_slot.sv
// +-----------------------------------------------------------------------------+
// | dispatch_slot : per-core FREE/LOAD/ACTIVE slot holding block id and count   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module dispatch_slot
    import gpu_dispatch_pkg::*;
#(
    parameter int BLOCK_ID_BITS = 8,
    parameter int TC_W          = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_issue,
    input  logic [BLOCK_ID_BITS-1:0] i_block_id,
    input  logic [TC_W-1:0]          i_thread_count,
    input  logic                     i_core_done,
    output logic                     o_free,
    output logic                     o_complete,
    output logic                     o_core_start,
    output logic                     o_core_reset,
    output logic [BLOCK_ID_BITS-1:0] o_block_id,
    output logic [TC_W-1:0]          o_thread_count
);

    slot_state_t              r_state;
    logic                     r_core_start;
    logic                     r_core_reset;
    logic [BLOCK_ID_BITS-1:0] r_block_id;
    logic [TC_W-1:0]          r_thread_count;

    // Core holds reset through LOAD so it sees a stable id/count before running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= FREE;
            r_core_start   <= 1'b0;
            r_core_reset   <= 1'b1;
            r_block_id     <= '0;
            r_thread_count <= '0;
        end else begin
            case (r_state)
                FREE: begin
                    if (i_issue) begin
                        r_state        <= LOAD;
                        r_block_id     <= i_block_id;
                        r_thread_count <= i_thread_count;
                    end
                end
                LOAD: begin
                    r_state      <= ACTIVE;
                    r_core_reset <= 1'b0;
                    r_core_start <= 1'b1;
                end
                ACTIVE: begin
                    if (i_core_done) begin
                        r_state      <= FREE;
                        r_core_start <= 1'b0;
                        r_core_reset <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= FREE;
                    r_core_start <= 1'b0;
                    r_core_reset <= 1'b1;
                end
            endcase
        end
    end

    assign o_free         = (r_state == FREE);
    assign o_complete     = (r_state == ACTIVE) && i_core_done;
    assign o_core_start   = r_core_start;
    assign o_core_reset   = r_core_reset;
    assign o_block_id     = r_block_id;
    assign o_thread_count = r_thread_count;

endmodule

`default_nettype wire

// File: rtl/block_dispatcher.sv
// +-----------------------------------------------------------------------------+
// | block_dispatcher : splits a kernel launch into blocks and issues them to    |
// | NUM_CORES cores. Optional busy-cycle counter via BLOCK_DISPATCHER_PERF_EN.  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
`default_nettype none

module block_dispatcher
    import gpu_dispatch_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_COUNT_BITS = 8,
    parameter int BLOCK_ID_BITS     = 8
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             start,
    input  logic [THREAD_COUNT_BITS-1:0]                     thread_count,
    input  logic [NUM_CORES-1:0]                             core_done,
    output logic [NUM_CORES-1:0]                             core_start,
    output logic [NUM_CORES-1:0]                             core_reset,
    output logic [NUM_CORES*BLOCK_ID_BITS-1:0]               core_block_id,
    output logic [NUM_CORES*($clog2(THREADS_PER_BLOCK)+1)-1:0] core_thread_count,
    output logic                                             done,
    output logic                                             busy
`ifdef BLOCK_DISPATCHER_PERF_EN
    ,
    output logic [31:0]                                      perf_cycles
`endif
);

    localparam int c_LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam int c_TC_W     = c_LOG2_TPB + 1;
    localparam int c_CW       = BLOCK_ID_BITS + 1;

    top_state_t                   r_state;
    logic [THREAD_COUNT_BITS-1:0] r_tc;
    logic [c_CW-1:0]              r_total;
    logic [c_CW-1:0]              r_dispatched;
    logic [c_CW-1:0]              r_completed;
    logic                         r_done;
    logic                         r_busy;

    logic [c_CW-1:0]              w_total;
    logic [c_CW-1:0]              w_ndone;
    logic [c_TC_W-1:0]            w_rem;
    logic [c_TC_W-1:0]            w_issue_count;
    logic [BLOCK_ID_BITS-1:0]     w_issue_id;
    logic                         w_last;
    logic                         w_can_issue;
    logic [NUM_CORES-1:0]         w_free;
    logic [NUM_CORES-1:0]         w_complete;
    logic [NUM_CORES-1:0]         w_lowest;
    logic [NUM_CORES-1:0]         w_issue;

    assign w_total       = c_CW'(ceil_div_pow2(32'(thread_count), c_LOG2_TPB));
    assign w_rem         = c_TC_W'(32'(r_tc) & (32'(THREADS_PER_BLOCK) - 32'd1));
    assign w_last        = (r_dispatched == r_total - c_CW'(1));
    assign w_issue_count = (w_last && (w_rem != '0)) ? w_rem : c_TC_W'(THREADS_PER_BLOCK);
    assign w_issue_id    = r_dispatched[BLOCK_ID_BITS-1:0];
    assign w_can_issue   = (r_state == RUN) && (r_dispatched < r_total);

    // Isolate the lowest set bit: deterministic lowest-index-free priority.
    assign w_lowest = w_free & (~w_free + NUM_CORES'(1));
    assign w_issue  = w_can_issue ? w_lowest : '0;

    always_comb begin
        w_ndone = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_ndone = w_ndone + c_CW'(w_complete[i]);
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
        dispatch_slot #(
            .BLOCK_ID_BITS (BLOCK_ID_BITS),
            .TC_W          (c_TC_W)
        ) u_slot (
            .clk            (clk),
            .reset          (reset),
            .i_issue        (w_issue[g]),
            .i_block_id     (w_issue_id),
            .i_thread_count (w_issue_count),
            .i_core_done    (core_done[g]),
            .o_free         (w_free[g]),
            .o_complete     (w_complete[g]),
            .o_core_start   (core_start[g]),
            .o_core_reset   (core_reset[g]),
            .o_block_id     (core_block_id[g*BLOCK_ID_BITS +: BLOCK_ID_BITS]),
            .o_thread_count (core_thread_count[g*c_TC_W +: c_TC_W])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_tc         <= '0;
            r_total      <= '0;
            r_dispatched <= '0;
            r_completed  <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tc         <= thread_count;
                        r_total      <= w_total;
                        r_dispatched <= '0;
                        r_completed  <= '0;
                        if (thread_count == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (|w_issue) begin
                        r_dispatched <= r_dispatched + c_CW'(1);
                    end
                    r_completed <= r_completed + w_ndone;
                    if (r_completed == r_total) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                DONE: begin
                    if (!start) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign done = r_done;
    assign busy = r_busy;

`ifdef BLOCK_DISPATCHER_PERF_EN
    logic [31:0] r_perf_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_cycles <= '0;
        end else if ((r_state == IDLE) && start && (thread_count != '0)) begin
            r_perf_cycles <= '0;
        end else if (r_busy && (r_perf_cycles != '1)) begin
            r_perf_cycles <= r_perf_cycles + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
`endif

endmodule

`default_nettype wire

// File: doc/block_dispatcher.md
Name: block_dispatcher

Overview:
Parametrised successor to the GPU's block dispatcher. Splits a kernel launch of thread_count threads into blocks of THREADS_PER_BLOCK and issues them to NUM_CORES cores, recycling cores as they finish. Adds the following over the current dispatcher:
- wide thread counts
- a partial final block
- one-dispatch-per-cycle deterministic ordering
- a busy flag
- an optional performance counter
Sits between the device control register and the core array at GPU top level.

Parameters:
NUM_CORES, 2, number of cores driven (>=1)
THREADS_PER_BLOCK, 4, threads per block; power of two, >=1
THREAD_COUNT_BITS, 8, width of thread_count input
BLOCK_ID_BITS, 8, width of issued block id; must hold ceil(2^THREAD_COUNT_BITS-1 / THREADS_PER_BLOCK)-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  launch request, level; held high for the kernel's duration
thread_count  in  THREAD_COUNT_BITS  total threads, sampled on launch
core_done  in  NUM_CORES  per-core completion, level
core_start  out  NUM_CORES  per-core run enable
core_reset  out  NUM_CORES  per-core reset, active-high
core_block_id  out  BLOCK_ID_BITS x NUM_CORES  block id per core
core_thread_count  out  $clog2(THREADS_PER_BLOCK)+1 x NUM_CORES  active threads in block
done  out  1  kernel complete
busy  out  1  kernel in progress

Behaviour:
- Reset (reset=0, async) drives:
  - core_reset all 1
  - core_start 0
  - core_block_id 0, core_thread_count 0
  - done 0, busy 0
  - Top FSM returns to IDLE; all counters are cleared.
- Top FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN: on start=1. Register thread_count; total_blocks = ceil(thread_count/THREADS_PER_BLOCK), computed by shift/mask; busy=1 the next cycle.
  - IDLE -> DONE: start=1 with thread_count=0. done=1 one cycle later; no core is ever started.
  - RUN -> DONE: when blocks_completed == total_blocks. done registers high one cycle after the last core_done is sampled; busy drops the same cycle.
  - DONE -> IDLE: when start=0. done clears the cycle after start falls.
- Per-core slot FSM states: FREE, LOAD, ACTIVE.
  - FREE -> LOAD: while RUN and blocks_dispatched < total_blocks, at most one dispatch per cycle, to the lowest-index FREE slot. In LOAD, core_reset=1, core_block_id=blocks_dispatched, core_thread_count=THREADS_PER_BLOCK. For the final block, core_thread_count = thread_count mod THREADS_PER_BLOCK if that is nonzero. blocks_dispatched increments.
  - LOAD -> ACTIVE: next cycle. core_reset=0, core_start=1.
  - ACTIVE -> FREE: core_done=1 sampled while ACTIVE. core_start=0 the next cycle; blocks_completed increments.
  - Multiple simultaneous core_done: all are counted in the same cycle (popcount add).
  - Slots in FREE keep core_reset=1 and core_start=0.
  - A slot freed in cycle N is eligible for dispatch in cycle N+1.
- core_done is ignored in FREE and LOAD.
- start falling during RUN is ignored; the kernel runs to completion.
- Counters are BLOCK_ID_BITS+1 wide; no wrap for legal parameters.
- Mid-operation reset aborts immediately; all outputs take their reset values.

Optional Feature:
- Macro: BLOCK_DISPATCHER_PERF_EN
- With the macro:
  - Adds output perf_cycles (32 bits), counting cycles with busy=1.
  - perf_cycles clears on the IDLE->RUN transition, holds in DONE, and saturates at all-ones.
- Without the macro: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package gpu_dispatch_pkg:
  - top-state enum {IDLE, RUN, DONE}
  - slot-state enum {FREE, LOAD, ACTIVE}
  - function ceil_div_pow2 (thread_count, log2 of THREADS_PER_BLOCK)
  - localparam TC_BITS = $clog2(THREADS_PER_BLOCK)+1
- Sub-module dispatch_slot, one instance per core:
  - holds the slot FSM and the block_id / thread_count registers
  - takes an issue strobe plus id/count
  - returns free and complete pulses
- The top module keeps the priority encoder, counters and top FSM.

Test Plan:
- NUM_CORES=2, TPB=4, thread_count=8, start held; each core asserts done 5 cycles after core_start -> core0 gets id0/count4 and core1 id1/count4, one cycle apart. done=1 one cycle after the second core_done; busy falls the same cycle.
- thread_count=10 -> 3 blocks. Block 2 goes to the first core freed, with core_thread_count=2; done follows that block's core_done.
- thread_count=0 -> done=1 one cycle after start; core_start never asserts; core_reset stays all-ones.
- Both cores assert core_done in the same cycle with total_blocks=2 -> blocks_completed=2 in one update; done the next cycle. Then start=0 -> done=0 the following cycle.
- reset pulled low mid-RUN while core1 is ACTIVE -> immediately core_start=0, core_reset=all-ones, busy=0. After release plus a new start with thread_count=4 -> block id restarts at 0.
- core_done pulsed while IDLE or while the slot is in LOAD -> no count change and no spurious done. With BLOCK_DISPATCHER_PERF_EN defined, perf_cycles equals the number of cycles busy was high.
